// File: rtl/dsp_i2s_tx.sv
// Philips I2S serializer for the S-DSP stereo output: one pair per frame,
// one-deep holding buffer, sticky overrun/underrun flags and a frame strobe.
module dsp_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_DIV     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    mute,
    input  logic                    clear_flags,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_sdata,
    output logic                    frame_start,
    output logic                    overrun,
    output logic                    underrun
);

    localparam int SLOTS = 2 * SAMPLE_WIDTH;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SLOT_W = $clog2(SLOTS);

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_next;
    logic [SLOTS-1:0]  holding;
    logic [SLOTS-1:0]  last_pair;
    logic [SLOTS-1:0]  load_pair;
    logic [SLOTS:0]    shift;
    logic              pending;
    logic              armed;
    logic              div_wrap;
    logic              phase_wrap;
    logic              boundary;

    always_comb begin
        div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
        phase_wrap = div_wrap && i2s_bclk;
        boundary   = phase_wrap && (slot == SLOT_W'(SLOTS - 1));
        slot_next  = slot;
        if (phase_wrap) begin
            slot_next = boundary ? '0 : slot + 1'b1;
        end
        load_pair = '0;
        if (!mute) begin
            load_pair = pending ? holding : last_pair;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            slot         <= '0;
            holding      <= '0;
            last_pair    <= '0;
            shift        <= '0;
            pending      <= 1'b0;
            armed        <= 1'b0;
            i2s_bclk     <= 1'b0;
            i2s_lrck     <= 1'b0;
            i2s_sdata    <= 1'b0;
            frame_start  <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                i2s_bclk <= ~i2s_bclk;
            end
            slot        <= slot_next;
            i2s_lrck    <= (slot_next >= SLOT_W'(SAMPLE_WIDTH));
            frame_start <= boundary;

            // Bit 0 carries the previous R LSB across the reload; it is the
            // bit driven at slot 0 of the new frame (one-BCLK I2S delay).
            if (phase_wrap) begin
                i2s_sdata <= shift[SLOTS];
                if (boundary) begin
                    shift     <= {load_pair, shift[SLOTS]};
                    last_pair <= load_pair;
                end else begin
                    shift <= {shift[SLOTS-1:0], 1'b0};
                end
            end

            if (sample_valid) begin
                holding <= {sample_l, sample_r};
                pending <= 1'b1;
                armed   <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            sample_ready <= ~(sample_valid | (pending & ~boundary));

            overrun  <= (sample_valid & pending & ~boundary) | (overrun & ~clear_flags);
            underrun <= (boundary & ~pending & armed) | (underrun & ~clear_flags);
        end
    end

endmodule

// File: doc/dsp_i2s_tx.md
Name: dsp_i2s_tx

Overview:
- Output serializer directly downstream of the S-DSP mixer.
- Accepts one signed stereo sample pair per 64-clock DSP sample period, in the format the DSP latches to its left/right DAC outputs at major step 63.
- Serializes the pair as a standard Philips I2S stream for an external codec: BCLK = clock/2, LRCK = 32 kHz at a 2.048 MHz clock.
- Provides a one-deep holding buffer, overrun/underrun detection, a mute control and a frame-start strobe the DSP can align to.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel slot; frame = 2*SAMPLE_WIDTH BCLK periods.
- BCLK_DIV, 1, clocks per BCLK half-period (≥1); frame length FRAME_CLKS = 4*SAMPLE_WIDTH*BCLK_DIV (64 by default).

Ports:
- clock  in  1  system clock, 2.048 MHz nominal
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- sample_l  in  SAMPLE_WIDTH  signed left sample
- sample_r  in  SAMPLE_WIDTH  signed right sample
- sample_valid  in  1  one-cycle strobe: capture sample_l/sample_r this edge
- sample_ready  out  1  high when holding buffer is empty (pending=0)
- mute  in  1  when high, frames loaded at the boundary carry zeros
- clear_flags  in  1  synchronous clear of the sticky flags
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- frame_start  out  1  one-cycle pulse in the first clock of each frame
- overrun  out  1  sticky: a sample was overwritten before transmission
- underrun  out  1  sticky: a frame boundary found no pending sample

Behaviour:
- Reset (reset=0, async) sets all state to zero:
  - counters, holding registers, pending, armed, shift register
  - i2s_bclk, i2s_lrck, i2s_sdata, frame_start, overrun, underrun
  - sample_ready=1.
- Timing: div counter 0..BCLK_DIV-1; bit_phase 0..1 advances on div wrap; slot counter b 0..2*SAMPLE_WIDTH-1 advances when bit_phase wraps. All outputs are registered.
- i2s_bclk = bit_phase: data changes while BCLK falls, and the codec samples on the rising edge.
- i2s_lrck = 0 for b in [0, SAMPLE_WIDTH-1] and 1 for b in [SAMPLE_WIDTH, 2*SAMPLE_WIDTH-1].
- i2s_sdata follows standard I2S with a one-BCLK delay (default widths):
  - b=1..16 carries L[16-b].
  - b=17..31 carries R[32-b].
  - b=0 carries R[0] of the previous frame.
- Implementation: a 2*SAMPLE_WIDTH+1 bit shift register, where bit 0 is the carried-over previous R LSB.
- Frame boundary = the edge on which the counters wrap to b=0, phase 0, div 0. frame_start=1 for exactly that following cycle.
- Capture: on sample_valid=1 → holding <= {sample_l, sample_r}, pending <= 1, armed <= 1.
  - If pending was already 1 and the same edge is not a boundary → overrun <= 1 (new data wins).
- At each boundary:
  - If pending=1 → load shift from holding (zeros if mute=1), pending <= 0.
  - If pending=0 → reload the last transmitted pair (zeros if mute=1). Set underrun <= 1 only if armed=1.
- Simultaneous boundary and sample_valid:
  - The boundary load uses the pre-edge holding contents.
  - The new pair is captured, leaving pending=1.
  - No overrun is flagged.
  - If nothing was pending before the edge → underrun, subject to armed.
- Latency: a pair captured at edge t begins at the next boundary; the left MSB appears on i2s_sdata one BCLK after that boundary.
- clear_flags clears overrun/underrun. A simultaneous set event wins over the clear.
- mute is sampled only at boundaries. A frame never changes mid-transmission.
- Reset mid-frame: outputs are immediately 0. After release, the first boundary is reached after exactly FRAME_CLKS clocks and transmits zeros.

Test Plan:
- Release reset, no stimulus for 3 frames → i2s_sdata constantly 0; frame_start pulses every 64 clocks; underrun stays 0 (not armed).
- sample_valid with L=16'hA5C3, R=16'h8001 mid-frame → at next boundary, LRCK low, bits 1..16 read A5C3 MSB-first, LRCK high at b=16, bits 17..31 read 800(0x0), then b=0 of the next frame shows R LSB=1; sample_ready low until boundary.
- Two sample_valid strobes 10 clocks apart within one frame (L=16'h1111, then 16'h2222) → overrun=1; next frame carries 16'h2222.
- Capture one pair, then stop → second boundary sets underrun=1 and repeats the same pair bit-for-bit; clear_flags → underrun=0.
- sample_valid coincident with boundary edge while pending=1 → old pair transmitted, new pair pending, overrun=0, underrun=0.
- mute=1 at boundary with pending L=16'h7FFF → all data bits 0 for that frame, pending cleared; assert reset mid-frame → all outputs 0 asynchronously.
